sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 compression stage.
- Reads NUM_OF_WORDS 32-bit message words from the shared word-addressed memory, starting at message_addr.
- Appends standard SHA-256 padding: a single 1 bit, zero fill, and a 64-bit big-endian bit length.
- Presents the result as 512-bit blocks over a valid/ready handshake, one block at a time.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..1000.
- NUM_BLOCKS, derived as (NUM_OF_WORDS+18)/16 (integer division), not overridable; value 2 at the default.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin a message; sampled only in IDLE.
- message_addr  input  16  word address of message word 0; latched when start is accepted.
- mem_clk  output  1  equals clk.
- mem_addr  output  16  registered read address.
- mem_read_data  input  32  read data; valid on the cycle after the address is presented.
- block_data  output  512  padded block; word 0 occupies bits [511:480], word 15 occupies bits [31:0].
- block_valid  output  1  block_data holds a complete block.
- block_ready  input  1  consumer accepts the block on a rising edge where valid and ready are both 1.
- block_last  output  1  the presented block is the final block; qualified by block_valid.
- busy  output  1  high from start acceptance until the last block is accepted.
- done  output  1  one-cycle pulse after the last block is accepted.

Behaviour:
- Reset values: mem_addr, block_data, block_valid, block_last, busy and done are all 0; state is IDLE. Reset applies immediately when asserted.
- States are IDLE, FILL, PRESENT and FINISH.
- IDLE:
  - On start=1, latch message_addr into base and clear blk (block counter) and rd_idx/wr_idx (4-bit plus a done flag).
  - Set busy=1 and go to FILL.
  - start while busy is ignored.
- FILL:
  - Each cycle, the read side issues index rd_idx. The global word index is g = blk*16 + rd_idx.
  - If g < NUM_OF_WORDS, mem_addr <= base + g, wrapping modulo 2^16. Otherwise mem_addr holds its last value.
  - A one-cycle pipelined tag carries g to the write side.
  - The write side stores word wr_idx of block_data on the following edge. The stored value is selected as:
    - g < NUM_OF_WORDS: mem_read_data.
    - g == NUM_OF_WORDS: 32'h80000000.
    - last block, word 14: 32'h00000000 (length high word).
    - last block, word 15: NUM_OF_WORDS*32, truncated to 32 bits.
    - otherwise: 0.
  - Padding words pass through the same one-cycle pipeline, so timing does not depend on content.
  - When word 15 is stored, set block_valid=1, set block_last=(blk==NUM_BLOCKS-1), and go to PRESENT.
- Latency:
  - Start is sampled at edge E0. The first block_valid is visible after edge E17.
  - Each subsequent block becomes valid 17 edges after the previous handshake.
- PRESENT:
  - block_data, block_valid and block_last stay stable while block_ready=0, for unbounded backpressure.
  - On a handshake, block_valid <= 0.
  - If block_last is set, go to FINISH. Otherwise blk <= blk+1, clear the indices and go to FILL.
  - There is no fetch overlap: the block is single-buffered.
- FINISH: done <= 1 for exactly one cycle, busy <= 0, block_last <= 0, then return to IDLE.
- Boundary cases:
  - NUM_OF_WORDS%16 == 13 gives an exact fit: 0x80000000 lands in word 13 of the final block.
  - NUM_OF_WORDS%16 == 14 or 15 causes an extra block, which contains only zeros plus the length.
- Changes to message_addr after acceptance have no effect.
- block_ready is a don't-care outside PRESENT.
- Reset mid-operation discards any partial block. No block_valid or done is produced for the aborted message.

Test Plan:
- Default (20 words), mem[0x0010+k]=k+1, block_ready tied to 1, start with message_addr=0x0010. Required response:
  - Block 0 holds words 1..16, with block_last=0.
  - Block 1 word0..3 = 17..20, word4=0x80000000, words 5..14 = 0, word15=0x00000280, with block_last=1.
  - done pulses once and busy falls in the same cycle.
- Backpressure: hold block_ready=0 for 10 cycles after the first block_valid. block_data, block_valid and block_last must stay constant. Block 1's valid rises 17 edges after the ready edge.
- NUM_OF_WORDS=13: exactly one block with block_last=1. Word12 is the last memory word, word13=0x80000000, word14=0, word15=0x000001A0.
- NUM_OF_WORDS=14: two blocks.
  - Block 0 word14=0x80000000 and word15=0.
  - Block 1 is all zero except word15=0x000001C0.
  - mem_addr never exceeds base+13.
- Assert reset on cycle 8 of FILL. All outputs go to 0 asynchronously. A new start then yields a full correct message from word 0.
- Pulse start and change message_addr while busy. Both are ignored: output blocks match the originally latched address, and there is a single done pulse.

Source files
------------

// File: rtl/sha256_msg_padder_if.sv
// Bundle of the start/memory/block handshake signals around the SHA-256 message padder.
// The padder connects through the slave modport; its environment uses master.
interface sha256_msg_padder_if;
  logic         start;
  logic [15:0]  message_addr;
  logic         mem_clk;
  logic [15:0]  mem_addr;
  logic [31:0]  mem_read_data;
  logic [511:0] block_data;
  logic         block_valid;
  logic         block_ready;
  logic         block_last;
  logic         busy;
  logic         done;

  modport slave (
    input  start, message_addr, mem_read_data, block_ready,
    output mem_clk, mem_addr, block_data, block_valid, block_last, busy, done
  );

  modport master (
    output start, message_addr, mem_read_data, block_ready,
    input  mem_clk, mem_addr, block_data, block_valid, block_last, busy, done
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// Fetches a NUM_OF_WORDS-word message from memory, appends SHA-256 padding and
// length, and hands out single-buffered 512-bit blocks over valid/ready.
module sha256_msg_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic               clk,
  input  logic               reset,
  sha256_msg_padder_if.slave bus
);
  localparam int NUM_BLOCKS = (NUM_OF_WORDS + 18) / 16;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_FINISH  = 2'd3;

  localparam logic [15:0] MSG_WORDS = 16'(NUM_OF_WORDS);
  localparam logic [11:0] LAST_BLK  = 12'(NUM_BLOCKS - 1);
  localparam logic [31:0] LEN_BITS  = 32'(NUM_OF_WORDS * 32);

  logic [1:0]  state;
  logic [15:0] base;
  logic [11:0] blk;
  logic [3:0]  rd_idx;
  logic [3:0]  wr_idx;
  logic        rd_done;
  logic [15:0] g_p0;
  logic [15:0] tag_p1;
  logic        vld_p1;
  logic [8:0]  word_lsb;

  // Message word, the 1-bit marker, or the length field depending on global word index.
  function automatic logic [31:0] pad_word(input logic [15:0] g, input logic last_blk,
                                           input logic [3:0] pos, input logic [31:0] mem_word);
    if (g < MSG_WORDS) return mem_word;
    if (g == MSG_WORDS) return 32'h8000_0000;
    if (last_blk && pos == 4'd15) return LEN_BITS;
    return 32'h0000_0000;
  endfunction

  assign g_p0        = {blk, rd_idx};
  assign word_lsb    = {~wr_idx, 5'b0_0000};
  assign bus.mem_clk = clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      base            <= '0;
      blk             <= '0;
      rd_idx          <= '0;
      wr_idx          <= '0;
      rd_done         <= 1'b0;
      tag_p1          <= '0;
      vld_p1          <= 1'b0;
      bus.mem_addr    <= '0;
      bus.block_data  <= '0;
      bus.block_valid <= 1'b0;
      bus.block_last  <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base     <= bus.message_addr;
            blk      <= '0;
            rd_idx   <= '0;
            wr_idx   <= '0;
            rd_done  <= 1'b0;
            vld_p1   <= 1'b0;
            bus.busy <= 1'b1;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          // p0: issue read address; padding slots keep the address but still flow down the pipe
          if (!rd_done) begin
            if (g_p0 < MSG_WORDS) bus.mem_addr <= base + g_p0;
            tag_p1  <= g_p0;
            rd_idx  <= rd_idx + 4'd1;
            rd_done <= (rd_idx == 4'd15);
          end
          vld_p1 <= !rd_done;
          // p1: read data has arrived; store the selected word into the block
          if (vld_p1) begin
            bus.block_data[word_lsb +: 32] <= pad_word(tag_p1, blk == LAST_BLK, wr_idx, bus.mem_read_data);
            wr_idx <= wr_idx + 4'd1;
            if (wr_idx == 4'd15) begin
              bus.block_valid <= 1'b1;
              bus.block_last  <= (blk == LAST_BLK);
              state           <= S_PRESENT;
            end
          end
        end
        S_PRESENT: begin
          if (bus.block_ready) begin
            bus.block_valid <= 1'b0;
            if (bus.block_last) begin
              state <= S_FINISH;
            end else begin
              blk     <= blk + 12'd1;
              rd_idx  <= '0;
              wr_idx  <= '0;
              rd_done <= 1'b0;
              vld_p1  <= 1'b0;
              state   <= S_FILL;
            end
          end
        end
        S_FINISH: begin
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          bus.block_last <= 1'b0;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Drives three padder instances (20, 13 and 14 words) with shared stimulus and
// checks every presented block against a reference padded-message scoreboard.
module tb_sha256_msg_padder;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] message_addr;
  logic        ready;

  int total = 0;
  int bad   = 0;
  int dones [3];
  int vseen [3];
  logic [15:0] max14;

  logic [512:0] q20 [$];
  logic [512:0] q13 [$];
  logic [512:0] q14 [$];

  sha256_msg_padder_if bus20 ();
  sha256_msg_padder_if bus13 ();
  sha256_msg_padder_if bus14 ();

  sha256_msg_padder #(.NUM_OF_WORDS(20)) u20 (.clk(clk), .reset(reset), .bus(bus20.slave));
  sha256_msg_padder #(.NUM_OF_WORDS(13)) u13 (.clk(clk), .reset(reset), .bus(bus13.slave));
  sha256_msg_padder #(.NUM_OF_WORDS(14)) u14 (.clk(clk), .reset(reset), .bus(bus14.slave));

  always #5 clk = ~clk;

  assign bus20.start = start;  assign bus20.message_addr = message_addr;  assign bus20.block_ready = ready;
  assign bus13.start = start;  assign bus13.message_addr = message_addr;  assign bus13.block_ready = ready;
  assign bus14.start = start;  assign bus14.message_addr = message_addr;  assign bus14.block_ready = ready;

  // Memory content: mem[0x0010 + k] = k + 1
  function automatic logic [31:0] memval(input logic [15:0] a);
    return {16'h0000, a} - 32'd15;
  endfunction

  always @(negedge bus20.mem_clk) bus20.mem_read_data <= memval(bus20.mem_addr);
  always @(negedge bus13.mem_clk) bus13.mem_read_data <= memval(bus13.mem_addr);
  always @(negedge bus14.mem_clk) bus14.mem_read_data <= memval(bus14.mem_addr);

  function automatic int nblk(input int n);
    return (n * 32 + 65 + 511) / 512;
  endfunction

  function automatic logic [512:0] exp_block(input int n, input logic [15:0] base, input int b);
    logic [511:0] d;
    logic [31:0]  w;
    int           i;
    int           nb;
    nb = nblk(n);
    d  = '0;
    for (int k = 0; k < 16; k++) begin
      i = b * 16 + k;
      if (i < n)                w = memval(base + 16'(i));
      else if (i == n)          w = 32'h8000_0000;
      else if (i == nb * 16 - 1) w = 32'(n * 32);
      else                      w = 32'h0;
      d[511 - 32 * k -: 32] = w;
    end
    return {(b == nb - 1), d};
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_msg(input logic [15:0] base);
    for (int b = 0; b < nblk(20); b++) q20.push_back(exp_block(20, base, b));
    for (int b = 0; b < nblk(13); b++) q13.push_back(exp_block(13, base, b));
    for (int b = 0; b < nblk(14); b++) q14.push_back(exp_block(14, base, b));
  endtask

  task automatic check_block(input int id, input logic [511:0] d, input logic l);
    logic [512:0] e;
    int           sz;
    sz = (id == 0) ? q20.size() : (id == 1) ? q13.size() : q14.size();
    chk($sformatf("blk%0d_expected", id), 512'(sz != 0), 512'd1);
    if (sz != 0) begin
      case (id)
        0:       e = q20.pop_front();
        1:       e = q13.pop_front();
        default: e = q14.pop_front();
      endcase
      chk($sformatf("blk%0d_data", id), d, e[511:0]);
      chk($sformatf("blk%0d_last", id), 512'(l), 512'(e[512]));
    end
  endtask

  always @(negedge clk) begin
    if (bus20.block_valid === 1'b1) begin vseen[0]++; if (ready) check_block(0, bus20.block_data, bus20.block_last); end
    if (bus13.block_valid === 1'b1) begin vseen[1]++; if (ready) check_block(1, bus13.block_data, bus13.block_last); end
    if (bus14.block_valid === 1'b1) begin vseen[2]++; if (ready) check_block(2, bus14.block_data, bus14.block_last); end
    if (bus20.done === 1'b1) begin dones[0]++; chk("busy_at_done20", 512'(bus20.busy), 512'd0); end
    if (bus13.done === 1'b1) begin dones[1]++; chk("busy_at_done13", 512'(bus13.busy), 512'd0); end
    if (bus14.done === 1'b1) begin dones[2]++; chk("busy_at_done14", 512'(bus14.busy), 512'd0); end
    if (bus14.busy === 1'b1 && bus14.mem_addr > max14) max14 = bus14.mem_addr;
  end

  task automatic do_start(input logic [15:0] a);
    @(posedge clk); #1;
    start        = 1'b1;
    message_addr = a;
    push_msg(a);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while ((bus20.busy || bus13.busy || bus14.busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", 512'(bus20.busy | bus13.busy | bus14.busy), 512'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_queues_and_dones(input string tag, input int d0, input int d1, input int d2);
    chk({tag, "_q20_empty"}, 512'(q20.size()), 512'd0);
    chk({tag, "_q13_empty"}, 512'(q13.size()), 512'd0);
    chk({tag, "_q14_empty"}, 512'(q14.size()), 512'd0);
    chk({tag, "_done20"}, 512'(dones[0] - d0), 512'd1);
    chk({tag, "_done13"}, 512'(dones[1] - d1), 512'd1);
    chk({tag, "_done14"}, 512'(dones[2] - d2), 512'd1);
  endtask

  initial begin
    int           e;
    int           d0, d1, d2;
    logic [511:0] snap_d;
    logic         snap_l;
    reset = 1'b1; start = 1'b0; ready = 1'b1; message_addr = 16'h0000;
    max14 = '0;
    for (int i = 0; i < 3; i++) begin dones[i] = 0; vseen[i] = 0; end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_addr", 512'(bus20.mem_addr), 512'd0);
    chk("rst_block_data", bus20.block_data, 512'd0);
    chk("rst_valid", 512'(bus20.block_valid), 512'd0);
    chk("rst_last", 512'(bus20.block_last), 512'd0);
    chk("rst_busy", 512'(bus20.busy), 512'd0);
    chk("rst_done", 512'(bus20.done), 512'd0);
    @(negedge clk) reset = 1'b0;

    // Default message with ready tied high; 13 and 14 word instances cover the boundary cases
    d0 = dones[0]; d1 = dones[1]; d2 = dones[2];
    max14 = '0;
    do_start(16'h0010);
    chk("busy_after_start", 512'(bus20.busy), 512'd1);
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!bus20.block_valid && e < 40);
    chk("first_valid_latency", 512'(e), 512'd17);
    wait_idle(200);
    check_queues_and_dones("default", d0, d1, d2);
    chk("n14_max_addr", 512'(max14), 512'(16'h0010 + 16'd13));

    // Backpressure for 10 cycles on the first block
    d0 = dones[0]; d1 = dones[1]; d2 = dones[2];
    ready = 1'b0;
    do_start(16'h0040);
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!bus20.block_valid && e < 40);
    chk("bp_first_latency", 512'(e), 512'd17);
    snap_d = bus20.block_data;
    snap_l = bus20.block_last;
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_data", bus20.block_data, snap_d);
      chk("bp_hold_valid", 512'(bus20.block_valid), 512'd1);
      chk("bp_hold_last", 512'(bus20.block_last), 512'(snap_l));
    end
    ready = 1'b1;
    @(posedge clk);
    e = 0;
    do begin @(posedge clk); #1; e++; end while (!bus20.block_valid && e < 40);
    chk("bp_second_latency", 512'(e), 512'd17);
    wait_idle(200);
    check_queues_and_dones("backpressure", d0, d1, d2);

    // Reset in the middle of FILL discards the message
    do_start(16'h0010);
    repeat (8) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_addr", 512'(bus20.mem_addr), 512'd0);
    chk("arst_block_data", bus20.block_data, 512'd0);
    chk("arst_valid", 512'(bus20.block_valid), 512'd0);
    chk("arst_last", 512'(bus20.block_last), 512'd0);
    chk("arst_busy", 512'(bus20.busy | bus13.busy | bus14.busy), 512'd0);
    chk("arst_done", 512'(bus20.done), 512'd0);
    q20.delete(); q13.delete(); q14.delete();
    @(negedge clk) reset = 1'b0;
    d0 = dones[0]; d1 = dones[1]; d2 = dones[2];
    e  = vseen[0] + vseen[1] + vseen[2];
    repeat (40) @(negedge clk);
    chk("aborted_no_done", 512'((dones[0] - d0) + (dones[1] - d1) + (dones[2] - d2)), 512'd0);
    chk("aborted_no_valid", 512'(vseen[0] + vseen[1] + vseen[2] - e), 512'd0);
    do_start(16'h0010);
    wait_idle(200);
    check_queues_and_dones("after_reset", d0, d1, d2);

    // start and message_addr changes while busy are ignored
    d0 = dones[0]; d1 = dones[1]; d2 = dones[2];
    do_start(16'h0200);
    repeat (5) @(posedge clk);
    #1;
    start        = 1'b1;
    message_addr = 16'h0300;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(200);
    repeat (30) @(negedge clk);
    check_queues_and_dones("busy_start", d0, d1, d2);
    chk("busy_start_idle", 512'(bus20.busy | bus13.busy | bus14.busy), 512'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
